// File: rtl/pwm_audio.sv
// 8-bit PWM for the mixed audio sample. The period is 256 clocks and the high time is mixed_sample clocks.
// Define PWM_FULL_SCALE_EN to make sample 255 give 100% duty (default build: 255/256).
module pwm_audio (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mixed_sample,
    input  logic       enable,
    output logic       PWM_o
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] cnt;
    logic             pwm_next_c;

    // Duty decision for the coming edge, taken from the pre-increment count
    always_comb begin
        pwm_next_c = (cnt < mixed_sample);
`ifdef PWM_FULL_SCALE_EN
        if (mixed_sample == 8'hFF) begin
            pwm_next_c = 1'b1;
        end
`else
        pwm_next_c = pwm_next_c;
`endif
    end

    // Period counter and registered output; reset takes priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            PWM_o <= 1'b0;
        end else if (!enable) begin
            cnt   <= '0;
            PWM_o <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            PWM_o <= pwm_next_c;
        end
    end

endmodule

// File: tb/tb_pwm_audio.sv
// Directed bench for pwm_audio. A per-edge model pushes the expected PWM_o into a scoreboard,
// and fixed-value checks cover the listed edges of each scenario.
module tb_pwm_audio;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mixed_sample = 8'd0;
    logic       enable = 1'b0;
    logic       PWM_o;

    int errors = 0;
    int checks = 0;
    int k = 0;

    bit    exp_q[$];
    string tag_q[$];

    pwm_audio dut (
        .clk          (tb_clk),
        .rst          (rst),
        .mixed_sample (mixed_sample),
        .enable       (enable),
        .PWM_o        (PWM_o)
    );

    always #5 tb_clk = ~tb_clk;

`ifdef PWM_FULL_SCALE_EN
    localparam bit FULL_SCALE = 1'b1;
`else
    localparam bit FULL_SCALE = 1'b0;
`endif

    // Models one rising edge from the current inputs, then compares PWM_o with the popped expectation
    task automatic tick(input string tag);
        bit    e;
        bit    got_e;
        string got_t;
        if (rst || !enable) begin
            k = 0;
            e = 1'b0;
        end else begin
            k = k + 1;
            e = (((k - 1) % 256) < int'(mixed_sample)) || (FULL_SCALE && mixed_sample == 8'hFF);
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge tb_clk);
        #1;
        got_e = exp_q.pop_front();
        got_t = tag_q.pop_front();
        checks++;
        assert (PWM_o === got_e) else begin
            errors++;
            $error("FAIL %s edge=%0d: PWM_o=%b expected=%b", got_t, k, PWM_o, got_e);
        end
    endtask

    // Fixed expected value taken straight from the scenario description
    task automatic chk(input string tag, input bit req);
        checks++;
        assert (PWM_o === req) else begin
            errors++;
            $error("FAIL %s: PWM_o=%b expected=%b", tag, PWM_o, req);
        end
    endtask

    task automatic step_to(input int target, input bit req, input string tag);
        while (k < target) tick(tag);
        chk($sformatf("%s@%0d", tag, target), req);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        tick("idle");
        chk("idle", 1'b0);
    endtask

    initial begin
        // Reset held for two edges with enable high and a nonzero sample
        rst = 1'b1; enable = 1'b1; mixed_sample = 8'd200;
        tick("rst1"); chk("rst1", 1'b0);
        tick("rst2"); chk("rst2", 1'b0);
        rst = 1'b0; enable = 1'b0;
        tick("post_rst"); chk("post_rst", 1'b0);

        // Half scale
        mixed_sample = 8'd127; enable = 1'b1;
        step_to(1, 1'b1, "half");
        step_to(127, 1'b1, "half");
        step_to(128, 1'b0, "half");
        step_to(129, 1'b0, "half");
        step_to(256, 1'b0, "half");
        step_to(257, 1'b1, "half");
        go_idle();

        // Zero
        mixed_sample = 8'd0; enable = 1'b1;
        step_to(1, 1'b0, "zero");
        step_to(127, 1'b0, "zero");
        step_to(128, 1'b0, "zero");
        step_to(256, 1'b0, "zero");
        step_to(257, 1'b0, "zero");
        go_idle();

        // Full scale
        mixed_sample = 8'd255; enable = 1'b1;
        step_to(1, 1'b1, "full");
        step_to(127, 1'b1, "full");
        step_to(128, 1'b1, "full");
        step_to(255, 1'b1, "full");
        step_to(256, FULL_SCALE, "full");
        step_to(257, 1'b1, "full");
        step_to(511, 1'b1, "full");
        step_to(512, FULL_SCALE, "full");
        step_to(513, 1'b1, "full");
        go_idle();

        // Enable gating and restart on re-enable
        mixed_sample = 8'd64; enable = 1'b1;
        step_to(64, 1'b1, "gate");
        step_to(100, 1'b0, "gate");
        enable = 1'b0;
        tick("gate_off"); chk("gate_off", 1'b0);
        enable = 1'b1;
        step_to(1, 1'b1, "reen");
        step_to(64, 1'b1, "reen");
        step_to(65, 1'b0, "reen");
        go_idle();

        // Mid-run reset clears the output and restarts the period
        mixed_sample = 8'd127; enable = 1'b1;
        step_to(49, 1'b1, "midrst");
        rst = 1'b1;
        tick("midrst_edge"); chk("midrst_edge", 1'b0);
        rst = 1'b0;
        step_to(1, 1'b1, "after_rst");
        step_to(127, 1'b1, "after_rst");
        step_to(128, 1'b0, "after_rst");

        // Sample change mid-period takes effect on the next edge
        mixed_sample = 8'd10;
        step_to(129, 1'b0, "change");
        go_idle();
        mixed_sample = 8'd10; enable = 1'b1;
        step_to(5, 1'b1, "change");
        mixed_sample = 8'd3;
        step_to(6, 1'b0, "change");
        mixed_sample = 8'd200;
        step_to(7, 1'b1, "change");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
